// File: rtl/ysyx_23060221_icache_pkg.sv
`default_nettype none
//============================================================================
// Module : ysyx_23060221_icache_pkg
// Brief  : Shared FSM encoding, AXI constants and address-field widths for
//          the direct-mapped instruction cache.
// Rev    : 1.0  initial release
//============================================================================
package ysyx_23060221_icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_AR = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFF_W = 2;
    localparam int ID_W       = 4;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060221_icache_array.sv
`default_nettype none
//============================================================================
// Module : ysyx_23060221_icache_array
// Brief  : Tag, valid and data storage; one combinational read port and one
//          word-write port that also updates the line's tag/valid.
// Rev    : 1.0  initial release
//============================================================================
module ysyx_23060221_icache_array
    import ysyx_23060221_icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_all,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [OFF_W-1:0]  rd_offset,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              meta_we,
    input  logic [TAG_W-1:0]  meta_tag,
    input  logic              meta_valid
);

    logic [DATA_W-1:0]    r_data [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;

    // Payload arrays carry no reset; only the valid bits define cache state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_data[wr_index][wr_offset] <= wr_data;
        end
        if (meta_we) begin
            r_tag[wr_index] <= meta_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush_all) begin
            r_valid <= '0;
        end else if (meta_we) begin
            r_valid[wr_index] <= meta_valid;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index][rd_offset];

endmodule
`default_nettype wire

// File: rtl/ysyx_23060221_icache.sv
`default_nettype none
//============================================================================
// Module : ysyx_23060221_icache
// Brief  : Direct-mapped blocking I-cache, AXI-style fetch slave and burst
//          refill master. Define ICACHE_PERF_EN to add hit/miss counters.
// Rev    : 1.0  initial release
//============================================================================
module ysyx_23060221_icache
    import ysyx_23060221_icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [ID_W-1:0]   s_rid,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);

    localparam int c_off_w = $clog2(LINE_WORDS);
    localparam int c_idx_w = $clog2(NUM_LINES);
    localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w - BYTE_OFF_W;
    localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic [1:0]          r_acc_resp;
    logic [c_off_w-1:0]  r_beat;

    logic [c_idx_w-1:0]  w_index;
    logic [c_off_w-1:0]  w_offset;
    logic [c_tag_w-1:0]  w_tag;
    logic                rd_valid;
    logic [c_tag_w-1:0]  rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                w_hit;
    logic                w_beat;
    logic                w_last;
    logic                w_short;
    logic [1:0]          w_final_resp;
    logic                w_unused;

    assign w_index  = r_addr[BYTE_OFF_W + c_off_w +: c_idx_w];
    assign w_offset = r_addr[BYTE_OFF_W +: c_off_w];
    assign w_tag    = r_addr[ADDR_W-1 -: c_tag_w];
    assign w_unused = &{1'b0, r_addr[BYTE_OFF_W-1:0]};

    assign w_hit        = rd_valid && (rd_tag == w_tag);
    assign w_beat       = (r_state == ST_REFILL) && m_rvalid;
    assign w_last       = w_beat && m_rlast;
    assign w_short      = (r_beat != c_last_beat);
    // First non-OKAY response of the burst wins; the current beat counts too.
    assign w_final_resp = (r_acc_resp == RESP_OKAY) ? m_rresp : r_acc_resp;

    ysyx_23060221_icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (c_tag_w),
        .IDX_W      (c_idx_w),
        .OFF_W      (c_off_w)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .flush_all  ((r_state == ST_IDLE) && flush),
        .rd_index   (w_index),
        .rd_offset  (w_offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (w_beat),
        .wr_index   (w_index),
        .wr_offset  (r_beat),
        .wr_data    (m_rdata),
        .meta_we    (w_last),
        .meta_tag   (w_tag),
        .meta_valid (!w_short && (w_final_resp == RESP_OKAY))
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (s_arvalid && s_arready) w_state_next = ST_LOOKUP;
            ST_LOOKUP:  w_state_next = w_hit ? ST_RESP : ST_MISS_AR;
            ST_MISS_AR: if (m_arready) w_state_next = ST_REFILL;
            ST_REFILL:  if (w_last) w_state_next = ST_RESP;
            ST_RESP:    if (s_rready) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_acc_resp <= RESP_OKAY;
            r_beat     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_arvalid && s_arready) begin
                        r_addr     <= s_araddr;
                        r_beat     <= '0;
                        r_acc_resp <= RESP_OKAY;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_rdata <= rd_data;
                        r_rresp <= RESP_OKAY;
                    end
                end
                ST_REFILL: begin
                    if (m_rvalid) begin
                        r_beat <= r_beat + c_off_w'(1);
                        if (r_beat == w_offset) begin
                            r_rdata <= m_rdata;
                        end
                        if (r_acc_resp == RESP_OKAY) begin
                            r_acc_resp <= m_rresp;
                        end
                        if (m_rlast) begin
                            r_rresp <= w_short ? RESP_SLVERR : w_final_resp;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // rst gates s_arready because the async reset parks the FSM in IDLE.
    assign s_arready = (r_state == ST_IDLE) && !flush && !rst;
    assign s_rvalid  = (r_state == ST_RESP);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rlast   = s_rvalid;
    assign s_rid     = '0;
    assign m_arvalid = (r_state == ST_MISS_AR);
    assign m_araddr  = {w_tag, w_index, {(c_off_w + BYTE_OFF_W){1'b0}}};
    assign m_arid    = '0;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign m_rready  = (r_state == ST_REFILL);

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit && (r_perf_hit != '1)) begin
                r_perf_hit <= r_perf_hit + 32'd1;
            end else if (!w_hit && (r_perf_miss != '1)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060221_icache.sv
`default_nettype none
//============================================================================
// Module : tb_ysyx_23060221_icache
// Brief  : Directed self-checking bench for the instruction cache.
// Rev    : 1.0  initial release
//============================================================================
module tb_ysyx_23060221_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    ysyx_23060221_icache dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
`ifdef ICACHE_PERF_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int arv_cnt = 0;
    int acc_cnt = 0;

    always @(posedge clk) begin
        if (m_arvalid) arv_cnt <= arv_cnt + 1;
        if (s_arvalid && s_arready) acc_cnt <= acc_cnt + 1;
    end

    logic [31:0] beat_d [4];
    logic [1:0]  beat_r [4];
    logic [31:0] cap_araddr;
    logic [7:0]  cap_arlen;
    logic [2:0]  cap_arsize;
    logic [1:0]  cap_arburst;
    logic [3:0]  cap_arid;
    bit          ar_stable;
    bit          ar_to;
    logic [31:0] got_d;
    logic [1:0]  got_r;
    bit          r_to;

    task automatic send_req(input logic [31:0] a);
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = a;
        @(negedge clk);
        s_arvalid = 1'b0;
    endtask

    task automatic serve_refill(input int nbeats, input int ar_delay);
        ar_to = 1'b1;
        ar_stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_arvalid) begin
                ar_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ar_to) return;
        cap_araddr = m_araddr; cap_arlen = m_arlen; cap_arsize = m_arsize;
        cap_arburst = m_arburst; cap_arid = m_arid;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            if (!m_arvalid || m_araddr !== cap_araddr) ar_stable = 1'b0;
        end
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = beat_d[i];
            m_rresp  = beat_r[i];
            m_rlast  = (i == nbeats - 1);
            @(negedge clk);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0;
    endtask

    task automatic take_resp();
        r_to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (s_rvalid) begin
                r_to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        got_d = s_rdata;
        got_r = s_rresp;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL reset_s_arready got %b exp 0", s_arready); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_s_rvalid got %b exp 0", s_rvalid); end
        checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b%b exp 00", m_arvalid, m_rready); end
        checks++; if (s_rdata !== 32'h0 || s_rresp !== 2'b00) begin errors++; $display("FAIL reset_s_rdata got %h/%b exp 0/00", s_rdata, s_rresp); end
        checks++; if (m_araddr !== 32'h0) begin errors++; $display("FAIL reset_m_araddr got %h exp 0", m_araddr); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL post_reset_s_arready got %b exp 1", s_arready); end
    endtask

    task automatic test_miss_refill();
        beat_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        beat_r = '{2'b00, 2'b00, 2'b00, 2'b00};
        send_req(32'h8000_0004);
        serve_refill(4, 2);
        checks++; if (ar_to) begin errors++; $display("FAIL miss_ar_timeout got none exp m_arvalid"); end
        checks++; if (cap_araddr !== 32'h8000_0000) begin errors++; $display("FAIL miss_araddr got %h exp 80000000", cap_araddr); end
        checks++; if (cap_arlen !== 8'd3 || cap_arsize !== 3'b010 || cap_arburst !== 2'b01 || cap_arid !== 4'd0) begin
            errors++; $display("FAIL miss_ar_fields got len %0d size %b burst %b id %0d exp 3 010 01 0", cap_arlen, cap_arsize, cap_arburst, cap_arid); end
        checks++; if (!ar_stable) begin errors++; $display("FAIL miss_ar_stable got unstable exp stable"); end
        take_resp();
        checks++; if (r_to || got_d !== 32'h22 || got_r !== 2'b00) begin
            errors++; $display("FAIL miss_resp got to=%0d %h/%b exp 00000022/00", r_to, got_d, got_r); end
    endtask

    task automatic test_hit();
        int arv0;
        arv0 = arv_cnt;
        send_req(32'h8000_000C);
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL hit_early_rvalid got %b exp 0", s_rvalid); end
        @(negedge clk);
        checks++; if (s_rvalid !== 1'b1 || s_rlast !== 1'b1 || s_rid !== 4'd0) begin
            errors++; $display("FAIL hit_latency got rvalid %b rlast %b rid %0d exp 1 1 0", s_rvalid, s_rlast, s_rid); end
        take_resp();
        checks++; if (got_d !== 32'h44 || got_r !== 2'b00) begin errors++; $display("FAIL hit_data got %h/%b exp 00000044/00", got_d, got_r); end
        checks++; if (arv_cnt !== arv0) begin errors++; $display("FAIL hit_no_refill got %0d exp %0d", arv_cnt, arv0); end
    endtask

    task automatic test_evict();
        beat_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        send_req(32'h8000_0100);
        serve_refill(4, 0);
        checks++; if (ar_to || cap_araddr !== 32'h8000_0100) begin errors++; $display("FAIL evict_araddr got to=%0d %h exp 80000100", ar_to, cap_araddr); end
        take_resp();
        checks++; if (got_d !== 32'hA0 || got_r !== 2'b00) begin errors++; $display("FAIL evict_data got %h/%b exp 000000a0/00", got_d, got_r); end
        beat_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_req(32'h8000_0004);
        serve_refill(4, 0);
        checks++; if (ar_to || cap_araddr !== 32'h8000_0000) begin errors++; $display("FAIL evict_remiss got to=%0d %h exp 80000000", ar_to, cap_araddr); end
        take_resp();
        checks++; if (got_d !== 32'h22) begin errors++; $display("FAIL evict_redata got %h exp 00000022", got_d); end
    endtask

    task automatic test_flush();
        int arv0;
        int acc0;
        arv0 = arv_cnt;
        send_req(32'h8000_000C);
        take_resp();
        checks++; if (arv_cnt !== arv0 || got_d !== 32'h44) begin errors++; $display("FAIL flush_prehit got arv %0d %h exp %0d 00000044", arv_cnt, got_d, arv0); end
        acc0 = acc_cnt;
        @(negedge clk);
        flush = 1'b1; s_arvalid = 1'b1; s_araddr = 32'h8000_000C;
        #1;
        checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL flush_arready got %b exp 0", s_arready); end
        @(negedge clk);
        flush = 1'b0; s_arvalid = 1'b0;
        checks++; if (acc_cnt !== acc0) begin errors++; $display("FAIL flush_accept got %0d exp %0d", acc_cnt, acc0); end
        beat_d = '{32'h55, 32'h66, 32'h77, 32'h88};
        send_req(32'h8000_000C);
        serve_refill(4, 0);
        checks++; if (ar_to || cap_araddr !== 32'h8000_0000) begin errors++; $display("FAIL flush_miss got to=%0d %h exp 80000000", ar_to, cap_araddr); end
        take_resp();
        checks++; if (got_d !== 32'h88) begin errors++; $display("FAIL flush_data got %h exp 00000088", got_d); end
    endtask

    task automatic test_err_resp();
        beat_d = '{32'h90, 32'h91, 32'h92, 32'h93};
        beat_r = '{2'b00, 2'b00, 2'b10, 2'b00};
        send_req(32'h8000_0020);
        serve_refill(4, 0);
        take_resp();
        checks++; if (got_r !== 2'b10) begin errors++; $display("FAIL err_resp got %b exp 10", got_r); end
        beat_r = '{2'b00, 2'b00, 2'b00, 2'b00};
        send_req(32'h8000_0020);
        serve_refill(4, 0);
        checks++; if (ar_to) begin errors++; $display("FAIL err_remiss got hit exp miss"); end
        take_resp();
        checks++; if (got_r !== 2'b00 || got_d !== 32'h90) begin errors++; $display("FAIL err_refill got %h/%b exp 00000090/00", got_d, got_r); end
    endtask

    task automatic test_short_burst();
        beat_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        send_req(32'h8000_0030);
        serve_refill(2, 0);
        take_resp();
        checks++; if (r_to || got_r !== 2'b10) begin errors++; $display("FAIL short_resp got to=%0d %b exp 10", r_to, got_r); end
        beat_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        send_req(32'h8000_0030);
        serve_refill(4, 0);
        checks++; if (ar_to) begin errors++; $display("FAIL short_remiss got hit exp miss"); end
        take_resp();
        checks++; if (got_d !== 32'hC0 || got_r !== 2'b00) begin errors++; $display("FAIL short_refill got %h/%b exp 000000c0/00", got_d, got_r); end
    endtask

    task automatic test_backpressure();
        int acc0;
        acc0 = acc_cnt;
        send_req(32'h8000_0034);
        @(negedge clk);
        s_arvalid = 1'b1; s_araddr = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            checks++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hC1 || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v%b %h/%b rdy%b exp v1 000000c1/00 rdy0", i, s_rvalid, s_rdata, s_rresp, s_arready); end
            @(negedge clk);
        end
        s_arvalid = 1'b0; s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        checks++; if (acc_cnt !== acc0 + 1) begin errors++; $display("FAIL bp_accepts got %0d exp %0d", acc_cnt - acc0, 1); end
        checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", s_rvalid); end
    endtask

    task automatic test_reset_mid_refill();
        bit seen;
        seen = 1'b0;
        send_req(32'h8000_0040);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_arvalid;
        end
        m_arready = 1'b1; @(negedge clk); m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD; m_rlast = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (!seen || m_rready !== 1'b0 || s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got seen %0d rready %b rvalid %b arready %b exp 1 0 0 0", seen, m_rready, s_rvalid, s_arready); end
        m_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        beat_d = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
        send_req(32'h8000_0040);
        serve_refill(4, 0);
        checks++; if (ar_to || cap_araddr !== 32'h8000_0040) begin errors++; $display("FAIL midrst_miss got to=%0d %h exp 80000040", ar_to, cap_araddr); end
        take_resp();
        checks++; if (got_d !== 32'hE0 || got_r !== 2'b00) begin errors++; $display("FAIL midrst_data got %h/%b exp 000000e0/00", got_d, got_r); end
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_hit();
        test_evict();
        test_flush();
        test_err_resp();
        test_short_burst();
        test_backpressure();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
